// File: rtl/dpram_loader.sv
// Write-side feeder for a dual-port RAM: sweeps the RAM to a fixed value, then turns
// the HPS download byte stream into port-A write cycles, packing byte pairs in 16-bit mode.
module dpram_loader #(
    parameter int                      addr_width_g  = 8,
    parameter int                      data_width_g  = 8,
    parameter logic [24:0]             base_addr_g   = 25'h0,
    parameter logic [data_width_g-1:0] clear_value_g = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear_req,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    ioctl_wait,
    output logic [addr_width_g-1:0] ram_address,
    output logic [data_width_g-1:0] ram_data,
    output logic                    ram_wren,
    output logic                    busy,
    output logic                    done
);

    localparam bit WIDE    = (data_width_g == 16);
    localparam int BYTE_AW = addr_width_g + (WIDE ? 1 : 0);

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD, FLUSH} state_t;

    state_t                  state, state_next;
    logic [addr_width_g-1:0] sweep, sweep_next;
    logic                    pending, pending_next;
    logic [7:0]              low_latch, low_latch_next;
    logic [addr_width_g-1:0] pend_addr, pend_addr_next;
    logic [addr_width_g-1:0] address_next;
    logic [data_width_g-1:0] data_next;
    logic                    wren_next, wait_next, done_next;

    logic [31:0]             off;
    logic                    in_range;
    logic [addr_width_g-1:0] word_addr;

    // Offset is taken in 32 bits so base + region size cannot wrap the 25-bit bus.
    assign off       = {7'd0, ioctl_addr} - {7'd0, base_addr_g};
    assign in_range  = (ioctl_addr >= base_addr_g) && (off < (32'd1 << BYTE_AW));
    assign word_addr = off[BYTE_AW-1 -: addr_width_g];
    assign busy      = (state != IDLE);

    always_comb begin
        state_next     = state;
        sweep_next     = sweep;
        pending_next   = pending;
        low_latch_next = low_latch;
        pend_addr_next = pend_addr;
        address_next   = ram_address;
        data_next      = ram_data;
        wren_next      = 1'b0;
        done_next      = 1'b0;
        wait_next      = (state == CLEAR) || (state == FLUSH);
        case (state)
            CLEAR: begin
                wren_next    = 1'b1;
                address_next = sweep;
                data_next    = clear_value_g;
                sweep_next   = sweep + addr_width_g'(1);
                if (&sweep) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            IDLE: begin
                if (ioctl_download) begin
                    state_next   = LOAD;
                    pending_next = 1'b0;
                end else if (clear_req) begin
                    state_next = CLEAR;
                    sweep_next = '0;
                end
            end
            LOAD: begin
                if (ioctl_wr && in_range) begin
                    if (!WIDE) begin
                        wren_next    = 1'b1;
                        address_next = word_addr;
                        data_next    = data_width_g'(ioctl_dout);
                    end else if (!off[0]) begin
                        low_latch_next = ioctl_dout;
                        pending_next   = 1'b1;
                        pend_addr_next = word_addr;
                    end else begin
                        // An odd byte always writes, even if its low half never arrived.
                        wren_next    = 1'b1;
                        address_next = word_addr;
                        data_next    = data_width_g'({ioctl_dout, low_latch});
                        pending_next = 1'b0;
                    end
                end
                if (!ioctl_download) state_next = FLUSH;
            end
            FLUSH: begin
                if (pending) begin
                    wren_next    = 1'b1;
                    address_next = pend_addr;
                    data_next    = data_width_g'(low_latch);
                    pending_next = 1'b0;
                end
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CLEAR;
            sweep       <= '0;
            pending     <= 1'b0;
            low_latch   <= 8'h00;
            pend_addr   <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            ioctl_wait  <= 1'b1;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            sweep       <= sweep_next;
            pending     <= pending_next;
            low_latch   <= low_latch_next;
            pend_addr   <= pend_addr_next;
            ram_address <= address_next;
            ram_data    <= data_next;
            ram_wren    <= wren_next;
            ioctl_wait  <= wait_next;
            done        <= done_next;
        end
    end

endmodule

// File: tb/tb_dpram_loader.sv
// Bench for dpram_loader: an 8-bit and a 16-bit instance share one download bus.
`timescale 1ns/1ps
module tb_dpram_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear_req;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        wait8, wren8, busy8, done8;
    logic [7:0]  addr8, data8;
    logic        wait16, wren16, busy16, done16;
    logic [7:0]  addr16;
    logic [15:0] data16;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dpram_loader #(.addr_width_g(8), .data_width_g(8), .base_addr_g(25'h100),
                   .clear_value_g(8'hA5)) u8 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(wait8), .ram_address(addr8), .ram_data(data8),
        .ram_wren(wren8), .busy(busy8), .done(done8));

    dpram_loader #(.addr_width_g(8), .data_width_g(16), .base_addr_g(25'h100),
                   .clear_value_g(16'h5A5A)) u16 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(wait16), .ram_address(addr16), .ram_data(data16),
        .ram_wren(wren16), .busy(busy16), .done(done16));

    typedef struct { int addr; int data; } wr_t;
    wr_t q8[$], q16[$], e8[$], e16[$];
    logic mon_en = 1'b0;

    // Reference model state: byte-level view of the download region.
    logic       m_pend = 1'b0;
    logic [7:0] m_latch = 8'h00;
    int         m_pword = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            wr_t w;
            if (wren8 === 1'b1) begin w.addr = int'(addr8); w.data = int'(data8); q8.push_back(w); end
            if (wren16 === 1'b1) begin w.addr = int'(addr16); w.data = int'(data16); q16.push_back(w); end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string name, logic [27:0] act_in, logic ew, logic [7:0] ea,
                           logic [15:0] ed, logic edn, logic ewt, logic eb);
        logic [27:0] act, exp;
        act = act_in;
        exp = {ew, ea, ed, edn, ewt, eb};
        if (!ew) begin act[26:3] = '0; exp[26:3] = '0; end
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual wren/addr/data/done/wait/busy %h required %h", name, act, exp);
        end
    endtask

    task automatic chk8(string name, logic ew, logic [7:0] ea, logic [15:0] ed,
                        logic edn, logic ewt, logic eb);
        chk_out(name, {wren8, addr8, 8'h00, data8, done8, wait8, busy8}, ew, ea, ed, edn, ewt, eb);
    endtask

    task automatic chk16(string name, logic ew, logic [7:0] ea, logic [15:0] ed,
                         logic edn, logic ewt, logic eb);
        chk_out(name, {wren16, addr16, data16, done16, wait16, busy16}, ew, ea, ed, edn, ewt, eb);
    endtask

    task automatic model_byte(logic [24:0] a, logic [7:0] d);
        int  ai = int'(a);
        wr_t w;
        if (ai >= 'h100 && ai < 'h200) begin
            w.addr = ai - 'h100; w.data = int'(d); e8.push_back(w);
        end
        if (ai >= 'h100 && ai < 'h300) begin
            int o = ai - 'h100;
            if (o % 2 == 0) begin
                m_latch = d; m_pend = 1'b1; m_pword = o / 2;
            end else begin
                w.addr = o / 2; w.data = int'(d) * 256 + int'(m_latch); e16.push_back(w);
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic model_flush();
        wr_t w;
        if (m_pend) begin w.addr = m_pword; w.data = int'(m_latch); e16.push_back(w); end
        m_pend = 1'b0;
    endtask

    task automatic strobe(logic [24:0] a, logic [7:0] d);
        @(negedge clock);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; clear_req = 1'b0;
        model_byte(a, d);
        @(negedge clock);
        ioctl_wr = 1'b0;
    endtask

    task automatic clear_check(string tag);
        int bad8 = 0, bad16 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (!(wren8 === 1'b1 && addr8 === 8'(i) && data8 === 8'hA5 && done8 === (i == 255)
                  && wait8 === 1'b1 && busy8 === (i != 255))) bad8++;
            if (!(wren16 === 1'b1 && addr16 === 8'(i) && data16 === 16'h5A5A && done16 === (i == 255)
                  && wait16 === 1'b1 && busy16 === (i != 255))) bad16++;
        end
        chk({tag, " clear8 bad cycles"}, bad8, 0);
        chk({tag, " clear16 bad cycles"}, bad16, 0);
        @(negedge clock);
        chk8({tag, " after clear8"}, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
        chk16({tag, " after clear16"}, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_values(string tag);
        chk8({tag, " ctl8"}, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 1'b1);
        chk16({tag, " ctl16"}, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 1'b1);
        chk({tag, " addr/data8"}, {addr8, data8}, 0);
        chk({tag, " addr/data16"}, {addr16, data16}, 0);
    endtask

    typedef struct {
        logic [24:0] addr; logic [7:0] dout;
        logic w8;  logic [7:0] a8;  logic [7:0]  d8;
        logic w16; logic [7:0] a16; logic [15:0] d16;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{25'h100, 8'h11, 1'b1, 8'h00, 8'h11, 1'b0, 8'h00, 16'h0000};
        tbl[1]  = '{25'h101, 8'h22, 1'b1, 8'h01, 8'h22, 1'b1, 8'h00, 16'h2211};
        tbl[2]  = '{25'h100, 8'h34, 1'b1, 8'h00, 8'h34, 1'b0, 8'h00, 16'h0000};
        tbl[3]  = '{25'h101, 8'h12, 1'b1, 8'h01, 8'h12, 1'b1, 8'h00, 16'h1234};
        tbl[4]  = '{25'h102, 8'h78, 1'b1, 8'h02, 8'h78, 1'b0, 8'h00, 16'h0000};
        tbl[5]  = '{25'h103, 8'h56, 1'b1, 8'h03, 8'h56, 1'b1, 8'h01, 16'h5678};
        tbl[6]  = '{25'h1FF, 8'h33, 1'b1, 8'hFF, 8'h33, 1'b1, 8'h7F, 16'h3378};
        tbl[7]  = '{25'h200, 8'h44, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};
        tbl[8]  = '{25'h0FF, 8'h66, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};
        tbl[9]  = '{25'h300, 8'h77, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};
        tbl[10] = '{25'h201, 8'h55, 1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 16'h5544};
        tbl[11] = '{25'h200, 8'hEE, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 16'h0000};
        tbl[12] = '{25'h2FF, 8'h99, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 16'h99EE};

        reset_n = 1'b1; clear_req = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset_values("reset");

        @(negedge clock);
        reset_n = 1'b1;
        clear_check("power-up");

        // Table-driven download through both instances
        @(negedge clock);
        ioctl_download = 1'b1; m_pend = 1'b0;
        for (int i = 0; i < 13; i++) begin
            strobe(tbl[i].addr, tbl[i].dout);
            chk8($sformatf("vec%0d 8bit", i), tbl[i].w8, tbl[i].a8, {8'h00, tbl[i].d8}, 1'b0, 1'b0, 1'b1);
            chk16($sformatf("vec%0d 16bit", i), tbl[i].w16, tbl[i].a16, tbl[i].d16, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clock);
        ioctl_download = 1'b0; model_flush();
        @(negedge clock);
        chk8("tbl flush 8", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
        chk16("tbl flush 16", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk8("tbl done 8", 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 1'b0);
        chk16("tbl done 16", 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 1'b0);

        // Odd-length download; the last byte arrives as download falls
        @(negedge clock);
        ioctl_download = 1'b1; m_pend = 1'b0;
        strobe(25'h100, 8'hAA);
        chk8("odd AA 8", 1'b1, 8'h00, 16'h00AA, 1'b0, 1'b0, 1'b1);
        chk16("odd AA 16", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
        strobe(25'h101, 8'hBB);
        chk8("odd BB 8", 1'b1, 8'h01, 16'h00BB, 1'b0, 1'b0, 1'b1);
        chk16("odd BB 16", 1'b1, 8'h00, 16'hBBAA, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        ioctl_wr = 1'b1; ioctl_addr = 25'h102; ioctl_dout = 8'hCC; ioctl_download = 1'b0;
        model_byte(25'h102, 8'hCC);
        @(negedge clock);
        ioctl_wr = 1'b0;
        chk8("fall CC 8", 1'b1, 8'h02, 16'h00CC, 1'b0, 1'b0, 1'b1);
        chk16("fall CC 16", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
        model_flush();
        @(negedge clock);
        chk8("flush 8", 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 1'b0);
        chk16("flush 16", 1'b1, 8'h01, 16'h00CC, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        chk8("post flush 8", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
        chk16("post flush 16", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);

        // Randomized downloads with clear_req noise, checked against the model's write stream
        for (int p = 0; p < 3; p++) begin
            @(posedge clock); #1;
            q8.delete(); q16.delete(); e8.delete(); e16.delete(); mon_en = 1'b1;
            @(negedge clock);
            ioctl_download = 1'b1; clear_req = 1'($urandom_range(0, 1)); m_pend = 1'b0;
            for (int k = 0; k < 30; k++) begin
                strobe(25'($urandom_range(32'h0F8, 32'h308)), 8'($urandom));
                clear_req = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 1)) begin
                    @(negedge clock);
                    clear_req = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clock);
            ioctl_download = 1'b0; clear_req = 1'b0; model_flush();
            repeat (4) @(negedge clock);
            @(posedge clock); #1 mon_en = 1'b0;
            chk($sformatf("rand%0d count8", p), q8.size(), e8.size());
            chk($sformatf("rand%0d count16", p), q16.size(), e16.size());
            for (int i = 0; i < q8.size() && i < e8.size(); i++)
                chk($sformatf("rand%0d w8[%0d]", p, i), {q8[i].addr[15:0], q8[i].data[15:0]},
                    {e8[i].addr[15:0], e8[i].data[15:0]});
            for (int i = 0; i < q16.size() && i < e16.size(); i++)
                chk($sformatf("rand%0d w16[%0d]", p, i), {q16[i].addr[15:0], q16[i].data[15:0]},
                    {e16[i].addr[15:0], e16[i].data[15:0]});
        end

        // clear_req in IDLE starts a full sweep one cycle later
        @(negedge clock);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        chk8("clrreq enter 8", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
        chk16("clrreq enter 16", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
        clear_check("clear_req");

        // Asynchronous reset with a low byte pending
        @(negedge clock);
        ioctl_download = 1'b1; m_pend = 1'b0;
        strobe(25'h100, 8'hDD);
        chk8("pre-rst 8", 1'b1, 8'h00, 16'h00DD, 1'b0, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("async reset");
        ioctl_download = 1'b0; m_pend = 1'b0; m_latch = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        clear_check("post-reset");
        repeat (3) @(negedge clock);
        chk("no pending write 16", {wren16, done16, busy16}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_loader.md
# dpram_loader

Write-side feeder for the dual-port RAM used across the Galaga core. On reset or on request, it clears the whole RAM to a fixed value. It then converts the HPS download byte stream (ioctl_*) into RAM write cycles on port A of `dpram`, packing bytes into words when the RAM is wider than 8 bits. It sits between the HPS I/O download bus and `dpram` port A. All RAM-side outputs connect directly to `address_a`, `data_a` and `wren_a`, with `clock_a` driven by the same clock.

## Interface
- addr_width_g, 8: RAM address width; must match the attached `dpram`.
- data_width_g, 8: RAM data width; only 8 or 16 are legal.
- base_addr_g, 25'h0: first ioctl byte address of this RAM's download region.
- clear_value_g, 0: word written to every location during clear.

- clock  in  1  single clock for all logic; same net as `dpram` `clock_a`.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; requests a full clear (honoured only in IDLE).
- ioctl_download  in  1  high for the duration of a download.
- ioctl_wr  in  1  one-cycle strobe; one byte valid on ioctl_dout/ioctl_addr.
- ioctl_addr  in  25  byte address of the strobed byte.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  stall request to the HPS; registered.
- ram_address  out  addr_width_g  to `address_a`; registered.
- ram_data  out  data_width_g  to `data_a`; registered.
- ram_wren  out  1  to `wren_a`; registered; high for exactly one cycle per write.
- busy  out  1  high in CLEAR, LOAD and FLUSH.
- done  out  1  one-cycle pulse when CLEAR or FLUSH completes.

## Operation
- Region size: R = 2^addr_width_g × (data_width_g/8) bytes.
- A byte is in range when base_addr_g ≤ ioctl_addr < base_addr_g + R. The offset is off = ioctl_addr − base_addr_g.
- FSM states: CLEAR, IDLE, LOAD, FLUSH.
- Reset values:
  - state = CLEAR, sweep counter = 0.
  - ram_address = 0, ram_data = 0, ram_wren = 0.
  - ioctl_wait = 1, busy = 1, done = 0.
  - Pending-byte flag = 0, low-byte latch = 0.
- CLEAR:
  - Each cycle writes clear_value_g at the sweep counter and increments it. This is one write per cycle, 2^addr_width_g writes in total.
  - After the write to the all-ones address, the FSM moves to IDLE and pulses done.
  - ioctl_wait stays 1 throughout. ioctl_wr is ignored.
- IDLE:
  - ioctl_download = 1 → LOAD, and the pending flag is cleared.
  - Otherwise clear_req = 1 → CLEAR with the sweep counter reset to 0.
  - If both are high, download wins.
- LOAD, 8-bit mode: an in-range ioctl_wr produces ram_address = off[addr_width_g-1:0], ram_data = ioctl_dout, ram_wren = 1.
- LOAD, 16-bit mode, little-endian:
  - Even off: latch ioctl_dout as the low byte and set the pending flag. No write.
  - Odd off: write {ioctl_dout, low latch} at off[addr_width_g:1] and clear the pending flag.
  - An odd byte with no pending flag still writes, using the current latch contents.
- Out-of-range strobes are ignored. Their state is untouched.
- clear_req is ignored in LOAD, CLEAR and FLUSH.
- LOAD with ioctl_download = 0 → FLUSH.
- FLUSH:
  - If the pending flag is set, write {8'h00, low latch} at the pending word address, then clear the flag.
  - Either way, go to IDLE next cycle and pulse done.
  - ioctl_wait = 1 in FLUSH.
- Data width: ram_data is always data_width_g wide. ioctl_addr bits above the region are not used for RAM addressing.
- Asynchronous reset mid-operation: all registers return to their reset values immediately and the FSM re-enters CLEAR. Any partial download is discarded.

## Timing
- Latency from ioctl_wr to ram_wren is 1 cycle; ram_address and ram_data are valid in the same cycle as ram_wren.
- ram_wren is never high for two consecutive cycles in LOAD, because ioctl_wr is a strobe.
- In CLEAR, ram_wren is high continuously for 2^addr_width_g cycles.
- ioctl_wait deasserts 1 cycle after IDLE is entered and reasserts in the cycle after entering CLEAR or FLUSH.
- CLEAR duration is 2^addr_width_g cycles, first write in the cycle after reset release. done pulses in the first IDLE cycle.
- An ioctl_wr in the cycle that ioctl_download falls is still processed by LOAD. FLUSH follows in the next cycle.
- The `dpram` port is WRITE_FIRST, so the loader needs no read-back or turnaround cycles.

## Test plan
- Reset release, addr_width_g = 8, clear_value_g = 8'hA5:
  - ram_wren high for 256 consecutive cycles, addresses 0..255, data A5.
  - done pulses once, ioctl_wait falls one cycle later.
- 8-bit download:
  - base_addr_g = 25'h100; bytes 11, 22, 33 at ioctl_addr 100h, 101h, 1FFh.
  - Writes at addresses 00, 01, FF with data 11, 22, 33, each one cycle after its strobe.
  - Byte at 200h (out of range) produces no write.
- 16-bit download:
  - Bytes 34, 12, 78, 56 at offsets 0..3 → word writes 1234 at address 0 and 5678 at address 1.
  - Exactly two ram_wren pulses.
- Odd-length 16-bit download:
  - Bytes AA, BB, CC, then ioctl_download falls.
  - FLUSH writes 00CC at address 1; done pulses; ioctl_wait is high for one cycle.
- clear_req in IDLE → full 256-cycle clear. clear_req during LOAD is ignored: no clear writes occur.
- reset_n pulled low mid-download, after offset 0 of a 16-bit pair:
  - Outputs drop to reset values asynchronously.
  - Clear restarts at address 0.
  - The pending byte is never written.
